// File: rtl/cr_huf_comp_sm_fifo_sched.sv
// Write scheduler for a small shared FIFO.
// N_REQ requesters compete round-robin for one FIFO write port. Each requester
// is capped at SRC_LIMIT resident entries, and the head of the FIFO is
// presented downstream with its source tag. A flush takes one CLR cycle that
// clears the FIFO and every occupancy count, then pulses flush_done.
module cr_huf_comp_sm_fifo_sched #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 55,
    parameter int DEPTH     = 6,
    parameter int SRC_LIMIT = 3,
    localparam int TAGW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_wen,
    output logic [TAGW+WIDTH-1:0]     fifo_wdata,
    output logic                      fifo_ren,
    output logic                      fifo_clear,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    input  logic                      fifo_underflow,
    input  logic                      fifo_overflow,
    input  logic [TAGW+WIDTH-1:0]     fifo_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [TAGW-1:0]           out_src,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      err,
    output logic [N_REQ*CW-1:0]       src_cnt
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_CLR = 1'b1
    } state_t;

    state_t            r_state;
    logic [TAGW-1:0]   r_rr_ptr;
    logic              r_err;
    logic              r_flush_done;
    logic [CW-1:0]     r_src_cnt [N_REQ];

    logic              w_active;
    logic [N_REQ-1:0]  w_eligible;
    logic [WIDTH-1:0]  w_req_data [N_REQ];
    logic              w_any_grant;
    logic [TAGW-1:0]   w_grant_idx;
    logic [TAGW-1:0]   w_scan_idx;
    logic [N_REQ-1:0]  w_grant;
    logic [TAGW-1:0]   w_rr_next;

    // Grants and reads happen only in RUN, outside reset, and not while a
    // flush is being requested (the flush cycle must not move data).
    assign w_active = (r_state == ST_RUN) && !rst && !flush;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign w_req_data[gi] = req_data[gi*WIDTH +: WIDTH];
        assign w_eligible[gi] = w_active && req_valid[gi] && !fifo_full &&
                                (r_src_cnt[gi] < CW'(SRC_LIMIT));
        assign w_grant[gi]    = w_any_grant && (w_grant_idx == TAGW'(gi));
    end

    // Round-robin search: first eligible requester at or above rr_ptr, wrapping.
    always_comb begin
        w_any_grant = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = TAGW'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_any_grant && w_eligible[w_scan_idx]) begin
                w_any_grant = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_rr_next  = (w_grant_idx == TAGW'(N_REQ - 1)) ? '0 : w_grant_idx + TAGW'(1);

    assign req_ready  = w_grant;
    assign fifo_wen   = w_any_grant;
    assign fifo_wdata = {w_grant_idx, w_req_data[w_grant_idx]};

    assign out_valid  = w_active && !fifo_empty;
    assign out_data   = fifo_rdata[WIDTH-1:0];
    assign out_src    = fifo_rdata[TAGW+WIDTH-1:WIDTH];
    assign fifo_ren   = out_valid && out_ready;
    assign fifo_clear = (r_state == ST_CLR) && !rst;

    assign flush_done = r_flush_done;
    assign err        = r_err;

    // Per-requester occupancy: +1 on a write tagged i, -1 on a read of tag i.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        logic w_inc;
        logic w_dec;
        assign w_inc = fifo_wen && (w_grant_idx == TAGW'(gi));
        assign w_dec = fifo_ren && (out_src == TAGW'(gi));
        assign src_cnt[gi*CW +: CW] = r_src_cnt[gi];

        // Track entries resident in the FIFO for this requester; zeroed by CLR.
        always_ff @(posedge clk) begin
            if (rst || r_state == ST_CLR) begin
                r_src_cnt[gi] <= '0;
            end else if (w_inc && !w_dec) begin
                r_src_cnt[gi] <= r_src_cnt[gi] + CW'(1);
            end else if (w_dec && !w_inc) begin
                r_src_cnt[gi] <= r_src_cnt[gi] - CW'(1);
            end
        end
    end

    // Control FSM with round-robin pointer, sticky error and flush_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_rr_ptr     <= '0;
            r_err        <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= (r_state == ST_CLR);
            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_CLR;
                    end
                    if (w_any_grant) begin
                        r_rr_ptr <= w_rr_next;
                    end
                    if (fifo_overflow || fifo_underflow) begin
                        r_err <= 1'b1;
                    end
                end
                ST_CLR: begin
                    r_state <= ST_RUN;
                    r_err   <= 1'b0;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_huf_comp_sm_fifo_sched.sv
// Bench for cr_huf_comp_sm_fifo_sched: a directed vector table for the named
// corner cases followed by randomized traffic, both checked against a
// queue-based model of FIFO contents (occupancy = tag count in the queue).
module tb_cr_huf_comp_sm_fifo_sched;

    localparam int N    = 4;
    localparam int W    = 55;
    localparam int D    = 6;
    localparam int LIM  = 3;
    localparam int TAGW = 2;
    localparam int CW   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*W-1:0]      req_data;
    logic [N-1:0]        req_ready;
    logic                fifo_wen;
    logic [TAGW+W-1:0]   fifo_wdata;
    logic                fifo_ren;
    logic                fifo_clear;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_underflow;
    logic                fifo_overflow;
    logic [TAGW+W-1:0]   fifo_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [TAGW-1:0]     out_src;
    logic                flush;
    logic                flush_done;
    logic                err;
    logic [N*CW-1:0]     src_cnt;

    cr_huf_comp_sm_fifo_sched #(
        .N_REQ(N), .WIDTH(W), .DEPTH(D), .SRC_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_ren(fifo_ren),
        .fifo_clear(fifo_clear), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_overflow(fifo_overflow),
        .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .flush(flush),
        .flush_done(flush_done), .err(err), .src_cnt(src_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic [TAGW+W-1:0] q[$];
    bit m_clr   = 1'b0;
    bit m_fd    = 1'b0;
    bit m_err   = 1'b0;
    bit m_known = 1'b0;
    int m_rr    = 0;

    // Outputs captured at the check point of the last step
    logic [N-1:0] cap_rdy;
    logic cap_clr, cap_fd, cap_err;

    typedef struct {
        bit           rst;
        bit           flush;
        bit           ovf;
        logic [N-1:0] rv;
        bit           ordy;
        logic [N-1:0] rdy;
        bit           clr;
        bit           fd;
        bit           err;
        bit           regs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit o, logic [N-1:0] rv, bit ordy,
                                logic [N-1:0] rdy, bit clr, bit fd, bit e, bit regs);
        vec_t v;
        v.rst = r; v.flush = f; v.ovf = o; v.rv = rv; v.ordy = ordy;
        v.rdy = rdy; v.clr = clr; v.fd = fd; v.err = e; v.regs = regs;
        return v;
    endfunction

    function automatic int count_tag(int t);
        int c = 0;
        foreach (q[j]) if (int'(q[j][TAGW+W-1:W]) == t) c++;
        return c;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against model, advance model.
    task automatic step(input bit rst_i, input bit flush_i, input bit ovf_i, input bit udf_i,
                        input logic [N-1:0] rv, input bit ordy);
        bit e_act, e_ov, e_ren, e_wen, e_clr;
        logic [N-1:0] e_rdy;
        logic [TAGW+W-1:0] e_wdata;
        int g, idx;
        @(negedge clk);
        rst            = rst_i;
        flush          = flush_i;
        fifo_overflow  = ovf_i;
        fifo_underflow = udf_i;
        req_valid      = rv;
        out_ready      = ordy;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'({$urandom, $urandom});
        fifo_full  = (q.size() >= D);
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() == 0) ? '0 : q[0];
        #1;
        e_clr = !rst_i && m_clr;
        e_act = !rst_i && !m_clr && !flush_i;
        e_ov  = e_act && (q.size() > 0);
        e_ren = e_ov && ordy;
        g = -1;
        if (e_act && q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && rv[idx] && count_tag(idx) < LIM) g = idx;
            end
        end
        e_wen = (g >= 0);
        e_rdy = '0;
        e_wdata = '0;
        if (e_wen) begin
            e_rdy[g] = 1'b1;
            e_wdata = {TAGW'(g), req_data[g*W +: W]};
        end
        check("req_ready",  64'(req_ready),  64'(e_rdy));
        check("fifo_wen",   64'(fifo_wen),   64'(e_wen));
        check("fifo_ren",   64'(fifo_ren),   64'(e_ren));
        check("fifo_clear", 64'(fifo_clear), 64'(e_clr));
        check("out_valid",  64'(out_valid),  64'(e_ov));
        if (e_wen) check("fifo_wdata", 64'(fifo_wdata), 64'(e_wdata));
        if (e_ov) begin
            check("out_data", 64'(out_data), 64'(q[0][W-1:0]));
            check("out_src",  64'(out_src),  64'(q[0][TAGW+W-1:W]));
        end
        if (m_known) begin
            check("flush_done", 64'(flush_done), 64'(m_fd));
            check("err",        64'(err),        64'(m_err));
            for (int i = 0; i < N; i++)
                check("src_cnt", 64'(src_cnt[i*CW +: CW]), 64'(count_tag(i)));
        end
        cap_rdy = req_ready;
        cap_clr = fifo_clear;
        cap_fd  = flush_done;
        cap_err = err;
        @(posedge clk);
        if (rst_i) begin
            m_clr = 0; m_fd = 0; m_err = 0; m_rr = 0; m_known = 1;
            q.delete();
        end else begin
            m_fd = m_clr;
            if (m_clr) begin
                m_err = 0;
                m_clr = 0;
                q.delete();
            end else begin
                if (ovf_i || udf_i) m_err = 1;
                if (flush_i) m_clr = 1;
                if (e_ren) void'(q.pop_front());
                if (e_wen) begin
                    q.push_back(e_wdata);
                    m_rr = (g + 1) % N;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b1; fifo_overflow = 1'b0;
        fifo_underflow = 1'b0; fifo_rdata = '0;

        //                  rst fl ovf rv       ordy rdy      clr fd err regs
        tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0)); // 0 reset
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, 1)); // 1 fairness
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0010, 0, 0, 0, 1)); // 2
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0100, 0, 0, 0, 1)); // 3
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b1000, 0, 0, 0, 1)); // 4
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0001, 0, 0, 0, 1)); // 5 wrap
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1)); // 6 drain
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0, 0, 0, 1)); // 7 src limit
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0, 0, 0, 1)); // 8
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0, 0, 0, 1)); // 9
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0000, 0, 0, 0, 1)); // 10 capped
        tbl.push_back(mk(0, 0, 0, 4'b0100, 1, 4'b0000, 0, 0, 0, 1)); // 11 one read
        tbl.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0, 0, 0, 1)); // 12 regrant
        tbl.push_back(mk(0, 0, 0, 4'b0011, 0, 4'b0001, 0, 0, 0, 1)); // 13 fill
        tbl.push_back(mk(0, 0, 0, 4'b0011, 0, 4'b0010, 0, 0, 0, 1)); // 14
        tbl.push_back(mk(0, 0, 0, 4'b0011, 0, 4'b0001, 0, 0, 0, 1)); // 15 now full
        tbl.push_back(mk(0, 0, 0, 4'b0011, 0, 4'b0000, 0, 0, 0, 1)); // 16 full blocks
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1)); // 17
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1)); // 18 four left
        tbl.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 1)); // 19 flush
        tbl.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0000, 1, 0, 0, 1)); // 20 CLR
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 1)); // 21 done
        tbl.push_back(mk(0, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 1)); // 22 overflow
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 1)); // 23 sticky
        tbl.push_back(mk(0, 0, 0, 4'b0010, 0, 4'b0010, 0, 0, 1, 1)); // 24
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 4'b0000, 0, 0, 1, 1)); // 25 flush
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 1, 0, 1, 1)); // 26 CLR
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 1)); // 27 err cleared
        tbl.push_back(mk(0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1)); // 28 flush
        tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1)); // 29 rst in CLR
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1)); // 30 no done
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 4'b0001, 0, 0, 0, 1)); // 31 rr reset
        tbl.push_back(mk(0, 0, 0, 4'b0001, 1, 4'b0001, 0, 0, 0, 1)); // 32 same src rd+wr

        foreach (tbl[v]) begin
            step(tbl[v].rst, tbl[v].flush, tbl[v].ovf, 1'b0, tbl[v].rv, tbl[v].ordy);
            check("tbl_req_ready", 64'(cap_rdy), 64'(tbl[v].rdy));
            check("tbl_fifo_clear", 64'(cap_clr), 64'(tbl[v].clr));
            if (tbl[v].regs) begin
                check("tbl_flush_done", 64'(cap_fd), 64'(tbl[v].fd));
                check("tbl_err", 64'(cap_err), 64'(tbl[v].err));
            end
            $display("vec %0d: rv=%b rdy=%b clr=%b fd=%b err=%b",
                     v, tbl[v].rv, cap_rdy, cap_clr, cap_fd, cap_err);
        end

        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 79) == 0,
                 N'($urandom),
                 (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cr_huf_comp_sm_fifo_sched.md
CR_HUF_COMP_SM_FIFO_SCHED -- requirements
Module: cr_huf_comp_sm_fifo_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of write requesters sharing one small FIFO.
REQ-002 SHALL have parameter WIDTH, default 55: payload width per requester.
REQ-003 SHALL have parameter DEPTH, default 6: attached FIFO depth.
REQ-004 SHALL have parameter SRC_LIMIT, default 3: maximum FIFO entries any one requester may hold.
REQ-005 SHALL derive TAGW = max(1, clog2(N_REQ)) and CW = clog2(DEPTH+1).
REQ-006 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock, reset synchronous and active-high.
REQ-007 SHALL have ports req_valid (in, N_REQ, per-requester valid), req_data (in, N_REQ*WIDTH, payload, requester i at bits [i*WIDTH +: WIDTH]) and req_ready (out, N_REQ, per-requester accept).
REQ-008 SHALL have ports fifo_wen (out, 1), fifo_wdata (out, TAGW+WIDTH, {tag, payload}), fifo_ren (out, 1) and fifo_clear (out, 1).
REQ-009 SHALL have ports fifo_full, fifo_empty, fifo_underflow, fifo_overflow (in, 1 each) and fifo_rdata (in, TAGW+WIDTH).
REQ-010 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, WIDTH) and out_src (out, TAGW).
REQ-011 SHALL have ports flush (in, 1, pulse), flush_done (out, 1, pulse), err (out, 1, sticky) and src_cnt (out, N_REQ*CW, per-requester occupancy).

Function
REQ-012 SHALL implement state machine RUN / CLR: RUN->CLR on flush=1; CLR->RUN unconditionally after one cycle.
REQ-013 In RUN, requester i SHALL be eligible when req_valid[i]=1, src_cnt[i]<SRC_LIMIT and fifo_full=0.
REQ-014 SHALL grant at most one eligible requester per cycle, round-robin, searching upward from rr_ptr with wrap at N_REQ.
REQ-015 SHALL set req_ready = one-hot grant (combinational), fifo_wen = |grant, fifo_wdata = {granted index, req_data of granted index}.
REQ-016 SHALL load rr_ptr with (granted index + 1) mod N_REQ on a grant; rr_ptr holds otherwise.
REQ-017 In RUN, SHALL drive out_valid = !fifo_empty, out_data = fifo_rdata[WIDTH-1:0], out_src = fifo_rdata[TAGW+WIDTH-1:WIDTH] and fifo_ren = out_valid & out_ready.
REQ-018 SHALL increment src_cnt[i] on a write tagged i and decrement src_cnt[out_src] on fifo_ren; when both hit the same i in one cycle, src_cnt[i] holds.
REQ-019 In CLR, SHALL force req_ready=0, fifo_wen=0, fifo_ren=0 and out_valid=0, assert fifo_clear=1, and zero all src_cnt at cycle end.
REQ-020 flush=1 in RUN SHALL block all grants and reads that same cycle; a write offered in that cycle is not accepted.
REQ-021 SHALL pulse flush_done for one cycle in the first RUN cycle after CLR; flush=1 during CLR SHALL be ignored.
REQ-022 SHALL set err on fifo_overflow or fifo_underflow, hold it until the CLR cycle, and clear it there.
REQ-023 SHALL keep each src_cnt within 0..SRC_LIMIT and the sum of src_cnt equal to FIFO used slots.

Reset
REQ-024 With rst=1 at a clk edge, SHALL set state=RUN, rr_ptr=0, all src_cnt=0, err=0 and flush_done=0.
REQ-025 While rst=1, SHALL hold req_ready, fifo_wen, fifo_ren, fifo_clear and out_valid at 0.
REQ-026 Reset asserted mid-operation SHALL abandon CLR without a flush_done pulse; the FIFO's own reset clears its contents.

Verification
REQ-027 SHALL cover fairness: N_REQ=4, all req_valid=1, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-028 SHALL cover source limit: only req 2 valid, out_ready=0 -> exactly 3 writes, then req_ready[2]=0 and src_cnt[2]=3; one read -> req 2 granted again the next cycle.
REQ-029 SHALL cover full FIFO: DEPTH=6, six writes from reqs 0/1, out_ready=0 -> fifo_full=1 and no req_ready asserted.
REQ-030 SHALL cover simultaneous write and read of the same source: src_cnt unchanged and out_src matches the write order.
REQ-031 SHALL cover flush with FIFO holding 4 entries and req_valid=1 -> one fifo_clear cycle with no write, src_cnt=0, flush_done one cycle later, err cleared.
REQ-032 SHALL cover injected fifo_overflow pulse -> err=1 held until the next flush.
